// File: rtl/dplca_pkg.sv
// dplca_pkg
// Shared definitions for the DPLCA TXOP claim-table aging block:
//   - dplca_state_e : aging FSM state encoding (visible on dplca_aging_state)
//   - CLAIM_*       : dplca_txop_claim codes from the PLCA RX observer
//   - ON/OFF, TRUE/FALSE : single-bit constants for enables and flags
package dplca_pkg;

    typedef enum logic [2:0] {
        S_DISABLED       = 3'd0,
        S_WAIT_TXOP_END  = 3'd1,
        S_TXOP_END       = 3'd2,
        S_UPDATE_CLAIMED = 3'd3,
        S_NOTIFY         = 3'd4,
        S_SCAN           = 3'd5
    } dplca_state_e;

    localparam logic [1:0] CLAIM_UNCLAIMED = 2'b00;
    localparam logic [1:0] CLAIM_CLAIMED   = 2'b01;

    localparam logic ON    = 1'b1;
    localparam logic OFF   = 1'b0;
    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

endpackage

// File: rtl/dplca_txop_aging_p_free_scan.sv
// dplca_free_scan
// Walks the live claim table SCAN_LANES entries per clock and reports the
// lowest unclaimed id (index 0 is never eligible).
// Optional macro DPLCA_TXOP_COUNT_EN adds a running count of claimed ids.
// Ports:
//   clk, reset_n    : clock, async active-low reset
//   clear           : synchronous abort/clear of the scan and its results
//   start           : one-cycle pulse; the scan runs on the following cycles
//   claim_table     : live table, held stable while the scan runs
//   done            : high during the last scan cycle
//   free_id/valid   : result, updated only when a scan completes
//   claimed_cnt     : (DPLCA_TXOP_COUNT_EN) set bits in 1..MAX_TXOP-1
module dplca_free_scan
    import dplca_pkg::*;
#(
    parameter int MAX_TXOP   = 256,
    parameter int ID_W       = 8,
    parameter int SCAN_LANES = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear,
    input  logic                start,
    input  logic [MAX_TXOP-1:0] claim_table,
    output logic                done,
    output logic [ID_W-1:0]     free_id,
    output logic                free_valid
`ifdef DPLCA_TXOP_COUNT_EN
    ,
    output logic [ID_W:0]       claimed_cnt
`endif
);

    localparam int N_CHUNK = MAX_TXOP / SCAN_LANES;
    localparam int CW      = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;
    localparam int LW      = (SCAN_LANES > 1) ? $clog2(SCAN_LANES) : 1;

    logic                  busy;
    logic [CW-1:0]         chunk_idx;
    logic                  hit_q;
    logic [ID_W-1:0]       hit_id_q;

    logic [SCAN_LANES-1:0] lanes_raw;
    logic [SCAN_LANES-1:0] lanes;
    logic                  lane_hit;
    logic [LW-1:0]         lane_sel;
    logic [ID_W-1:0]       cand_id;

    always_comb begin
        lanes_raw = '0;
        for (int c = 0; c < N_CHUNK; c++) begin
            if (chunk_idx == CW'(c)) begin
                lanes_raw = claim_table[c*SCAN_LANES +: SCAN_LANES];
            end
        end
        // id 0 is reserved, so it never counts as free
        lanes = lanes_raw;
        if (chunk_idx == '0) begin
            lanes[0] = TRUE;
        end
        // descending loop leaves the lowest free lane selected
        lane_hit = FALSE;
        lane_sel = '0;
        for (int i = SCAN_LANES - 1; i >= 0; i--) begin
            if (!lanes[i]) begin
                lane_hit = TRUE;
                lane_sel = LW'(i);
            end
        end
        cand_id = ID_W'(chunk_idx) * ID_W'(SCAN_LANES) + ID_W'(lane_sel);
    end

    assign done = busy && (chunk_idx == CW'(N_CHUNK - 1));

`ifdef DPLCA_TXOP_COUNT_EN
    logic [SCAN_LANES-1:0] cnt_lanes;
    logic [ID_W:0]         chunk_pop;
    logic [ID_W:0]         acc_q;
    logic [ID_W:0]         acc_next;

    always_comb begin
        cnt_lanes = lanes_raw;
        if (chunk_idx == '0) begin
            cnt_lanes[0] = FALSE;
        end
        chunk_pop = '0;
        for (int i = 0; i < SCAN_LANES; i++) begin
            chunk_pop = chunk_pop + (ID_W+1)'(cnt_lanes[i]);
        end
        acc_next = acc_q + chunk_pop;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q       <= '0;
            claimed_cnt <= '0;
        end else if (clear) begin
            acc_q       <= '0;
            claimed_cnt <= '0;
        end else if (start) begin
            acc_q <= '0;
        end else if (busy) begin
            acc_q <= acc_next;
            if (done) begin
                claimed_cnt <= acc_next;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy       <= FALSE;
            chunk_idx  <= '0;
            hit_q      <= FALSE;
            hit_id_q   <= '0;
            free_id    <= '0;
            free_valid <= FALSE;
        end else if (clear) begin
            busy       <= FALSE;
            chunk_idx  <= '0;
            hit_q      <= FALSE;
            hit_id_q   <= '0;
            free_valid <= FALSE;
        end else if (start) begin
            busy      <= TRUE;
            chunk_idx <= '0;
            hit_q     <= FALSE;
            hit_id_q  <= '0;
        end else if (busy) begin
            if (!hit_q && lane_hit) begin
                hit_q    <= TRUE;
                hit_id_q <= cand_id;
            end
            if (done) begin
                busy       <= FALSE;
                chunk_idx  <= '0;
                free_valid <= hit_q || lane_hit;
                if (hit_q) begin
                    free_id <= hit_id_q;
                end else if (lane_hit) begin
                    free_id <= cand_id;
                end else begin
                    free_id <= '0;
                end
            end else begin
                chunk_idx <= chunk_idx + CW'(1);
            end
        end
    end

endmodule

// File: rtl/dplca_txop_aging_p.sv
// dplca_txop_aging_p
// DPLCA TXOP claim-table aging machine. Records claims from the PLCA RX
// observer, ages the live table from the "new" table every aging_cycles+1
// id-0 transactions, finds the lowest free id and acknowledges the observer
// with a 4-phase handshake (dplca_txop_end / dplca_txop_table_upd).
// Optional macro DPLCA_TXOP_COUNT_EN adds dplca_claimed_cnt.
// Ports:
//   clk, reset_n               : clock, async active-low reset
//   dplca_aging                : enable, low forces DISABLED
//   dplca_txop_end/claim/id    : observed transaction (request level)
//   aging_cycles               : id-0 transactions between aging events
//   txop_claim_table[_new]     : live / since-last-aging claim tables
//   dplca_aging_state          : FSM state
//   aging_cnt                  : aging counter
//   dplca_new_age              : aging happened in this transaction
//   dplca_txop_table_upd       : acknowledge
//   dplca_free_id/valid        : lowest free id in 1..MAX_TXOP-1
//   dplca_txop_id_err          : sticky out-of-range id flag
//   dplca_claimed_cnt          : (DPLCA_TXOP_COUNT_EN) claimed id count
//
// state            | meaning
// DISABLED         | aging off, tables and flags held clear
// WAIT_TXOP_END    | idle, waiting for an observed transaction
// TXOP_END         | claim/id captured, aging evaluated on id 0
// UPDATE_CLAIMED   | set the claimed id in both tables
// SCAN             | searching the live table for the lowest free id
// NOTIFY           | acknowledge held until txop_end drops
module dplca_txop_aging_p
    import dplca_pkg::*;
#(
    parameter int MAX_TXOP   = 256,
    parameter int ID_W       = 8,
    parameter int AGING_W    = 16,
    parameter int SCAN_LANES = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                dplca_aging,
    input  logic                dplca_txop_end,
    input  logic [1:0]          dplca_txop_claim,
    input  logic [ID_W-1:0]     dplca_txop_id,
    input  logic [AGING_W-1:0]  aging_cycles,
    output logic [MAX_TXOP-1:0] txop_claim_table,
    output logic [MAX_TXOP-1:0] txop_claim_table_new,
    output logic [2:0]          dplca_aging_state,
    output logic [AGING_W-1:0]  aging_cnt,
    output logic                dplca_new_age,
    output logic                dplca_txop_table_upd,
    output logic [ID_W-1:0]     dplca_free_id,
    output logic                dplca_free_valid,
    output logic                dplca_txop_id_err
`ifdef DPLCA_TXOP_COUNT_EN
    ,
    output logic [ID_W:0]       dplca_claimed_cnt
`endif
);

    dplca_state_e         state_q;
    dplca_state_e         state_d;
    logic [1:0]           claim_q;
    logic [ID_W-1:0]      id_q;
    logic                 id_bad;
    logic [MAX_TXOP-1:0]  id_mask;
    logic                 clr;
    logic                 scan_start;
    logic                 scan_done;

    assign dplca_aging_state = state_q;

    // clearing on the edge that enters DISABLED as well as while in it keeps
    // everything zero from the first DISABLED cycle onwards
    assign clr = (dplca_aging == OFF) || (state_q == S_DISABLED);

    assign id_bad = {1'b0, id_q} >= (ID_W+1)'(MAX_TXOP);

    always_comb begin
        id_mask = '0;
        for (int i = 0; i < MAX_TXOP; i++) begin
            id_mask[i] = (id_q == ID_W'(i));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_DISABLED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (dplca_aging == OFF) begin
            state_d = S_DISABLED;
        end else begin
            case (state_q)
                S_DISABLED:       state_d = S_WAIT_TXOP_END;
                S_WAIT_TXOP_END:  if (dplca_txop_end) state_d = S_TXOP_END;
                S_TXOP_END:       state_d = (claim_q == CLAIM_CLAIMED) ? S_UPDATE_CLAIMED : S_SCAN;
                S_UPDATE_CLAIMED: state_d = S_SCAN;
                S_SCAN:           if (scan_done) state_d = S_NOTIFY;
                S_NOTIFY:         if (!dplca_txop_end) state_d = S_WAIT_TXOP_END;
                default:          state_d = S_DISABLED;
            endcase
        end
        scan_start = (state_d == S_SCAN) && (state_q != S_SCAN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            txop_claim_table     <= '0;
            txop_claim_table_new <= '0;
            aging_cnt            <= '0;
            dplca_new_age        <= FALSE;
            dplca_txop_id_err    <= FALSE;
            claim_q              <= '0;
            id_q                 <= '0;
        end else if (clr) begin
            txop_claim_table     <= '0;
            txop_claim_table_new <= '0;
            aging_cnt            <= '0;
            dplca_new_age        <= FALSE;
            dplca_txop_id_err    <= FALSE;
        end else begin
            case (state_q)
                S_WAIT_TXOP_END: begin
                    dplca_new_age <= FALSE;
                    if (dplca_txop_end) begin
                        claim_q <= dplca_txop_claim;
                        id_q    <= dplca_txop_id;
                    end
                end
                S_TXOP_END: begin
                    if (id_bad) begin
                        dplca_txop_id_err <= TRUE;
                    end
                    if (id_q == '0) begin
                        if (aging_cnt >= aging_cycles) begin
                            txop_claim_table     <= txop_claim_table_new;
                            txop_claim_table_new <= '0;
                            aging_cnt            <= '0;
                            dplca_new_age        <= TRUE;
                        end else if (aging_cnt != '1) begin
                            aging_cnt <= aging_cnt + AGING_W'(1);
                        end
                    end
                end
                S_UPDATE_CLAIMED: begin
                    if (!id_bad) begin
                        txop_claim_table     <= txop_claim_table | id_mask;
                        txop_claim_table_new <= txop_claim_table_new | id_mask;
                    end
                end
                S_NOTIFY: begin
                    if (!dplca_txop_end) begin
                        dplca_new_age <= FALSE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dplca_txop_table_upd <= FALSE;
        end else begin
            dplca_txop_table_upd <= (state_d == S_NOTIFY);
        end
    end

    dplca_free_scan #(
        .MAX_TXOP   (MAX_TXOP),
        .ID_W       (ID_W),
        .SCAN_LANES (SCAN_LANES)
    ) u_free_scan (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (clr),
        .start       (scan_start),
        .claim_table (txop_claim_table),
        .done        (scan_done),
        .free_id     (dplca_free_id),
        .free_valid  (dplca_free_valid)
`ifdef DPLCA_TXOP_COUNT_EN
        ,
        .claimed_cnt (dplca_claimed_cnt)
`endif
    );

endmodule

// File: tb/tb_dplca_txop_aging_p.sv
module tb_dplca_txop_aging_p;

    localparam int MT = 12;
    localparam int IW = 4;
    localparam int AW = 16;
    localparam int SL = 4;
    localparam int NC = MT / SL;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          dplca_aging = 1'b0;
    logic          dplca_txop_end = 1'b0;
    logic [1:0]    dplca_txop_claim = 2'b00;
    logic [IW-1:0] dplca_txop_id = '0;
    logic [AW-1:0] aging_cycles = '0;
    logic [MT-1:0] txop_claim_table;
    logic [MT-1:0] txop_claim_table_new;
    logic [2:0]    dplca_aging_state;
    logic [AW-1:0] aging_cnt;
    logic          dplca_new_age;
    logic          dplca_txop_table_upd;
    logic [IW-1:0] dplca_free_id;
    logic          dplca_free_valid;
    logic          dplca_txop_id_err;
`ifdef DPLCA_TXOP_COUNT_EN
    logic [IW:0]   dplca_claimed_cnt;
`endif

    always #5 clk = ~clk;

    dplca_txop_aging_p #(
        .MAX_TXOP(MT), .ID_W(IW), .AGING_W(AW), .SCAN_LANES(SL)
    ) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .dplca_aging          (dplca_aging),
        .dplca_txop_end       (dplca_txop_end),
        .dplca_txop_claim     (dplca_txop_claim),
        .dplca_txop_id        (dplca_txop_id),
        .aging_cycles         (aging_cycles),
        .txop_claim_table     (txop_claim_table),
        .txop_claim_table_new (txop_claim_table_new),
        .dplca_aging_state    (dplca_aging_state),
        .aging_cnt            (aging_cnt),
        .dplca_new_age        (dplca_new_age),
        .dplca_txop_table_upd (dplca_txop_table_upd),
        .dplca_free_id        (dplca_free_id),
        .dplca_free_valid     (dplca_free_valid),
        .dplca_txop_id_err    (dplca_txop_id_err)
`ifdef DPLCA_TXOP_COUNT_EN
        ,
        .dplca_claimed_cnt    (dplca_claimed_cnt)
`endif
    );

    // transaction-level expectation of every output
    logic [MT-1:0] m_live = '0;
    logic [MT-1:0] m_new = '0;
    int            m_state = 0;
    int            m_cnt = 0;
    bit            m_age = 0;
    bit            m_upd = 0;
    bit            m_valid = 0;
    bit            m_err = 0;
    int            m_fid = 0;
    int            m_ccnt = 0;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic void m_clear();
        m_live  = '0;
        m_new   = '0;
        m_cnt   = 0;
        m_age   = 0;
        m_upd   = 0;
        m_valid = 0;
        m_err   = 0;
        m_ccnt  = 0;
        m_state = 0;
    endfunction

    // lowest free id in 1..MT-1 and number of claimed ids there
    function automatic void m_scan();
        m_valid = 0;
        m_fid   = 0;
        m_ccnt  = 0;
        for (int i = 1; i < MT; i++) begin
            if (m_live[i]) m_ccnt++;
            else if (!m_valid) begin
                m_valid = 1;
                m_fid   = i;
            end
        end
    endfunction

    always @(negedge clk) begin
        chk("state", dplca_aging_state, m_state);
        chk("live_table", txop_claim_table, m_live);
        chk("new_table", txop_claim_table_new, m_new);
        chk("aging_cnt", aging_cnt, m_cnt);
        chk("new_age", dplca_new_age, m_age);
        chk("table_upd", dplca_txop_table_upd, m_upd);
        chk("free_id", dplca_free_id, m_fid);
        chk("free_valid", dplca_free_valid, m_valid);
        chk("id_err", dplca_txop_id_err, m_err);
`ifdef DPLCA_TXOP_COUNT_EN
        chk("claimed_cnt", dplca_claimed_cnt, m_ccnt);
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one full handshake; abort drops dplca_aging at a random scan cycle
    task automatic txn(input logic [1:0] c, input logic [IW-1:0] i, input bit abort);
        int cap_id;
        bit clm;
        int abort_at;
        cap_id = int'(i);
        clm    = (c == 2'b01);
        dplca_txop_end   = 1'b1;
        dplca_txop_claim = c;
        dplca_txop_id    = i;
        tick();
        m_state = 2;
        dplca_txop_claim = 2'($urandom);
        dplca_txop_id    = IW'($urandom);
        tick();
        if (cap_id == 0) begin
            if (m_cnt >= int'(aging_cycles)) begin
                m_live = m_new;
                m_new  = '0;
                m_cnt  = 0;
                m_age  = 1;
            end else if (m_cnt < 65535) begin
                m_cnt++;
            end
        end
        if (cap_id >= MT) m_err = 1;
        m_state = clm ? 3 : 5;
        if (clm) begin
            tick();
            if (cap_id < MT) begin
                m_live[cap_id] = 1'b1;
                m_new[cap_id]  = 1'b1;
            end
            m_state = 5;
        end
        abort_at = abort ? $urandom_range(0, NC - 1) : NC;
        for (int k = 0; k < NC; k++) begin
            if (k == abort_at) begin
                dplca_aging    = 1'b0;
                dplca_txop_end = 1'b0;
                tick();
                m_clear();
                dplca_aging = 1'b1;
                tick();
                m_state = 1;
                return;
            end
            tick();
        end
        m_scan();
        m_state = 4;
        m_upd   = 1;
        repeat ($urandom_range(0, 3)) tick();
        dplca_txop_end = 1'b0;
        tick();
        m_state = 1;
        m_upd   = 0;
        m_age   = 0;
        repeat ($urandom_range(0, 2)) tick();
    endtask

    task automatic idle_disable();
        dplca_aging = 1'b0;
        tick();
        m_clear();
        repeat ($urandom_range(0, 2)) tick();
        dplca_aging = 1'b1;
        tick();
        m_state = 1;
    endtask

    initial begin
        logic [1:0]    rc;
        logic [IW-1:0] rid;

        reset_n     = 1'b0;
        dplca_aging = 1'b1;
        repeat (3) tick();
        chk("rst_state", dplca_aging_state, 3'd0);
        chk("rst_live", txop_claim_table, 12'h000);
        chk("rst_upd", dplca_txop_table_upd, 1'b0);
        reset_n = 1'b1;
        tick();
        m_state = 1;
        chk("en_state", dplca_aging_state, 3'd1);

        aging_cycles = 16'd2;
        txn(2'b01, 4'd3, 0);
        chk("claim3_live", txop_claim_table, 12'h008);
        chk("claim3_new", txop_claim_table_new, 12'h008);
        chk("claim3_free_id", dplca_free_id, 4'd1);
        chk("claim3_valid", dplca_free_valid, 1'b1);

        txn(2'b01, 4'd5, 0);
        txn(2'b00, 4'd0, 0);
        chk("age_cnt1", aging_cnt, 16'd1);
        txn(2'b00, 4'd0, 0);
        chk("age_cnt2", aging_cnt, 16'd2);
        txn(2'b00, 4'd0, 0);
        chk("age_cnt0", aging_cnt, 16'd0);
        chk("age_live_kept", txop_claim_table, 12'h028);
        chk("age_new_clr", txop_claim_table_new, 12'h000);
        repeat (3) txn(2'b00, 4'd0, 0);
        chk("age2_live_clr", txop_claim_table, 12'h000);

        for (int k = 1; k < MT; k++) txn(2'b01, IW'(k), 0);
        chk("full_valid", dplca_free_valid, 1'b0);
        chk("full_id", dplca_free_id, 4'd0);
        txn(2'b01, 4'd13, 0);
        chk("bad_id_err", dplca_txop_id_err, 1'b1);
        chk("bad_id_tbl", txop_claim_table, 12'hFFE);

        txn(2'b01, 4'd2, 1);
        chk("abort_state", dplca_aging_state, 3'd1);
        chk("abort_live", txop_claim_table, 12'h000);
        chk("abort_valid", dplca_free_valid, 1'b0);

        txn(2'b01, 4'd2, 0);
        txn(2'b01, 4'd7, 0);
        txn(2'b01, 4'd9, 0);
`ifdef DPLCA_TXOP_COUNT_EN
        chk("cnt3", dplca_claimed_cnt, 5'd3);
`endif
        chk("cnt3_free_id", dplca_free_id, 4'd1);

        for (int n = 0; n < 160; n++) begin
            if ($urandom_range(0, 7) == 0) aging_cycles = AW'($urandom_range(0, 3));
            rc  = 2'($urandom);
            if ($urandom_range(0, 2) == 0) rc = 2'b01;
            rid = ($urandom_range(0, 3) == 0) ? IW'(0) : IW'($urandom_range(1, 15));
            txn(rc, rid, $urandom_range(0, 9) == 0);
            if ($urandom_range(0, 19) == 0) idle_disable();
        end

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
